prg_rom_loader: RTL

Loadable, parametrised PRG program memory for the NES CPU test environment. It replaces the fixed, combinational test-program ROM with a synchronous memory that is flood-filled with NOP on reset. A byte-stream loader can then overwrite any region, so test programs and vectors are loaded at run time rather than compiled in. The block sits on the CPU's $8000–$FFFF read path and holds the CPU in reset while contents are being written.

---
 rtl/prg_rom_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/prg_rom_loader.sv
// Loadable PRG program memory: flood-filled with FILL after reset, then overwritten
// by a byte-stream loader (addr lo/hi, len lo/hi, payload) while the CPU is held.
module prg_rom_loader #(
  parameter int          ADDR_W = 15,
  parameter logic [7:0]  FILL   = 8'hEA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  output logic [7:0]  cpu_data,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  // Handshake: a loader byte transfers on a rising edge where ld_valid && ld_ready;
  // ld_ready is decoded from the state alone, ld_valid may be held low indefinitely.
  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    LEN_LO  = 3'd3,
    LEN_HI  = 3'd4,
    DATA    = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        addr_lo, len_lo;
  logic [15:0]       wr_ptr, remaining;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem [DEPTH];

  assign accept    = ld_valid & ld_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = clr_cnt;
    mem_wdata = FILL;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (&clr_cnt) state_nxt = ADDR_LO;
      end
      ADDR_LO: begin
        ld_ready = 1'b1;
        cpu_hold = 1'b0;
        if (ld_valid) state_nxt = ADDR_HI;
      end
      ADDR_HI: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        ld_ready = 1'b1;
        if (ld_valid) state_nxt = ({ld_data, len_lo} == 16'd0) ? DONE : DATA;
      end
      DATA: begin
        ld_ready  = 1'b1;
        mem_we    = ld_valid;
        mem_idx   = wr_ptr[ADDR_W-1:0];
        mem_wdata = ld_data;
        if (ld_valid && remaining == 16'd1) state_nxt = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_nxt = ADDR_LO;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt   <= '0;
      addr_lo   <= 8'h00;
      len_lo    <= 8'h00;
      wr_ptr    <= 16'h0000;
      remaining <= 16'h0000;
      err       <= 1'b0;
      cpu_data  <= FILL;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        case (state)
          ADDR_LO: addr_lo <= ld_data;
          ADDR_HI: begin
            wr_ptr <= {ld_data, addr_lo};
            // Load still proceeds through the index mapping; only flag it.
            if (!ld_data[7]) err <= 1'b1;
          end
          LEN_LO:  len_lo <= ld_data;
          LEN_HI:  remaining <= {ld_data, len_lo};
          DATA: begin
            wr_ptr    <= wr_ptr + 16'd1;
            remaining <= remaining - 16'd1;
          end
          default: ;
        endcase
      end
      // Forcing FILL during hold also hides any same-cycle write/read collision.
      cpu_data <= cpu_hold ? FILL : mem[cpu_addr[ADDR_W-1:0]];
    end
  end

  // Storage has no reset; CLEAR rewrites every location after each reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  // Address bits above the index are intentionally ignored (mirroring).
  logic unused_hi_bits;
  assign unused_hi_bits = ^{cpu_addr, wr_ptr};

endmodule
